ff_shift_univ: RTL and testbench

//  Parametrised universal register: WIDTH-bit bank of D flip-flops with enable, synchronous

---
 rtl/ff_shift_univ.sv | 119 +++++++++++
 tb/tb_ff_shift_univ.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ff_shift_univ.sv
// Universal WIDTH-bit register: load, shift, rotate, arithmetic shift, sync clear, saturating shift count.
// Optional build macro FF_SHIFT_PARITY_EN adds a registered parity output 'par'.
module ff_shift_univ #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         clr,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         full
`ifdef FF_SHIFT_PARITY_EN
    ,
    output logic                         par
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_op;

    // Next-state: clr beats en; every shift/rotate bumps the saturating counter
    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        shift_op = 1'b0;
        if (clr) begin
            q_d   = RESET_VAL;
            cnt_d = '0;
        end else if (en) begin
            case (mode)
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], sin_r};
                    shift_op = 1'b1;
                end
                MODE_SHR: begin
                    q_d      = {sin_l, q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_ROTL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    shift_op = 1'b1;
                end
                MODE_ROTR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_ASHR: begin
                    q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_HOLD: q_d = q_q;
                default:   q_d = q_q;
            endcase
            if (shift_op && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef FF_SHIFT_PARITY_EN
    logic par_q, par_d;

    // Parity of the word being written, so par tracks ^q without a combinational XOR tree on q
    always_comb begin
        par_d = ^q_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= ^RESET_VAL;
        end else begin
            par_q <= par_d;
        end
    end

    assign par = par_q;
`endif

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign cnt    = cnt_q;
    assign full   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_ff_shift_univ.sv
// Scoreboard bench for ff_shift_univ (WIDTH=8, RESET_VAL=0); checks par when FF_SHIFT_PARITY_EN is defined.
module tb_ff_shift_univ;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] cnt;
    logic       full;
`ifdef FF_SHIFT_PARITY_EN
    logic       par;
`endif

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ff_shift_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .clr    (clr),
        .mode   (mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .cnt    (cnt),
        .full   (full)
`ifdef FF_SHIFT_PARITY_EN
        ,
        .par    (par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] eq, input logic [3:0] ec);
        logic ef;
        logic [7:0] qv;
        ef = (ec == 4'd8);
        qv = eq;
        checks++;
        if (q !== eq || cnt !== ec || full !== ef || sout_l !== qv[7] || sout_r !== qv[0]) begin
            errors++;
            $display("FAIL %s: got q=%h cnt=%0d full=%b sl=%b sr=%b, want q=%h cnt=%0d full=%b sl=%b sr=%b",
                     name, q, cnt, full, sout_l, sout_r, eq, ec, ef, qv[7], qv[0]);
        end
`ifdef FF_SHIFT_PARITY_EN
        checks++;
        if (par !== ^eq) begin
            errors++;
            $display("FAIL %s par: got %b want %b", name, par, ^eq);
        end
`endif
    endtask

    // Monitor: each rising edge presents the result of the vector issued before it
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("step", e.q, e.cnt);
        end
    end

    task automatic step(input logic e, input logic c, input logic [2:0] m, input logic [7:0] dd,
                        input logic sl, input logic sr, input logic [7:0] eq, input logic [3:0] ec);
        exp_t x;
        @(negedge clk);
        en = e; clr = c; mode = m; d = dd; sin_l = sl; sin_r = sr;
        x.q = eq;
        x.cnt = ec;
        exp_q.push_back(x);
    endtask

    initial begin
        int wait_cyc;
        reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 8'h00, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        // load then shift-left, then hold with en=0
        step(1, 0, 3'b001, 8'hA5, 0, 0, 8'hA5, 4'd0);
        step(1, 0, 3'b010, 8'h00, 0, 1, 8'h4B, 4'd1);
        step(0, 0, 3'b010, 8'h00, 0, 1, 8'h4B, 4'd1);

        // async reset asserted mid-clock clears immediately
        step(1, 0, 3'b001, 8'hA5, 0, 0, 8'hA5, 4'd0);
        @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        check("async_reset", 8'h00, 4'd0);
        @(negedge clk);
        en = 1'b1; mode = 3'b001; d = 8'h5A;
        @(posedge clk);
        #2;
        check("reset_held", 8'h00, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        // first edge after release executes; 8 rotl returns word, 9th saturates
        step(1, 0, 3'b001, 8'h81, 0, 0, 8'h81, 4'd0);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h03, 4'd1);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h06, 4'd2);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h0C, 4'd3);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h18, 4'd4);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h30, 4'd5);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h60, 4'd6);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'hC0, 4'd7);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h81, 4'd8);
        step(1, 0, 3'b100, 8'h00, 0, 0, 8'h03, 4'd8);
        step(1, 0, 3'b000, 8'h00, 0, 0, 8'h03, 4'd8);

        // arithmetic shift then logical shift right
        step(1, 0, 3'b001, 8'h90, 0, 0, 8'h90, 4'd0);
        step(1, 0, 3'b110, 8'h00, 0, 0, 8'hC8, 4'd1);
        step(1, 0, 3'b011, 8'h00, 0, 0, 8'h64, 4'd2);

        // rotr, shr with sin_l=1, shl with sin_r=0, hold and reserved mode
        step(1, 0, 3'b001, 8'h01, 0, 0, 8'h01, 4'd0);
        step(1, 0, 3'b101, 8'h00, 0, 0, 8'h80, 4'd1);
        step(1, 0, 3'b011, 8'h00, 1, 0, 8'hC0, 4'd2);
        step(1, 0, 3'b010, 8'h00, 1, 0, 8'h80, 4'd3);
        step(1, 0, 3'b000, 8'hFF, 1, 1, 8'h80, 4'd3);
        step(1, 0, 3'b111, 8'hFF, 1, 1, 8'h80, 4'd3);

        // clr beats load; reserved mode holds; clr works with en=0
        step(1, 1, 3'b001, 8'hFF, 0, 0, 8'h00, 4'd0);
        step(1, 0, 3'b111, 8'hFF, 0, 0, 8'h00, 4'd0);
        step(1, 0, 3'b001, 8'h3C, 0, 0, 8'h3C, 4'd0);
        step(1, 0, 3'b010, 8'h00, 0, 0, 8'h78, 4'd1);
        step(0, 1, 3'b001, 8'hFF, 0, 0, 8'h00, 4'd0);

        // parity pattern
        step(1, 0, 3'b001, 8'h07, 0, 0, 8'h07, 4'd0);
        step(1, 0, 3'b010, 8'h00, 0, 1, 8'h0F, 4'd1);
        step(0, 0, 3'b000, 8'h00, 0, 0, 8'h0F, 4'd1);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
